// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for the 5-stage pipeline (FD, DE, EM, MW).
//
// - Detects read-after-write hazards between the decode instruction and older
//   producers in DE, EM and MW.
// - Resolves them either by stalling only (FWD_EN=0) or by forwarding from
//   EM/MW and stalling on load-use only (FWD_EN=1).
// - Squashes the younger instruction on a taken branch resolved in execute.
// - Keeps saturating stall/flush counters, a registered record of the last
//   action, and a sticky watchdog that trips on an over-long stall run.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   fd_*              decode instruction: valid, source specifiers, used flags
//   de_*              execute instruction: valid, RegWrite, MemRead, rd/rs/rt
//   em_*, mw_*        later producers: valid, RegWrite, rd
//   br_taken          taken branch/jump resolved in execute this cycle
//   stall             hold PC and the FD register
//   insert_nop        load a bubble into DE on the next edge
//   flush_fd          invalidate the FD register on the next edge
//   fwd_a, fwd_b      execute operand select: 00 regfile, 10 EM, 01 MW
//   hz_state          last-cycle action: 00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt         saturating count of STALL cycles
//   flush_cnt         saturating count of FLUSH cycles
//   stall_timeout     sticky watchdog error
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW    = 3,
    parameter int FWD_EN    = 1,
    parameter int R0_ZERO   = 0,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fd_valid,
    input  logic              fd_rs_used,
    input  logic              fd_rt_used,
    input  logic [REG_AW-1:0] fd_rs,
    input  logic [REG_AW-1:0] fd_rt,
    input  logic              de_valid,
    input  logic              de_RegWrite,
    input  logic              de_MemRead,
    input  logic [REG_AW-1:0] de_rd,
    input  logic [REG_AW-1:0] de_rs,
    input  logic [REG_AW-1:0] de_rt,
    input  logic              em_valid,
    input  logic              em_RegWrite,
    input  logic [REG_AW-1:0] em_rd,
    input  logic              mw_valid,
    input  logic              mw_RegWrite,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic              br_taken,
    output logic              stall,
    output logic              insert_nop,
    output logic              flush_fd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        hz_state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              stall_timeout
);

    typedef enum logic [1:0] {
        HZ_RUN   = 2'b00,
        HZ_STALL = 2'b01,
        HZ_FLUSH = 2'b10
    } hz_t;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_EM = 2'b10;
    localparam logic [1:0] SEL_MW = 2'b01;

    // run_len must be able to hold MAX_STALL so it can saturate there
    // instead of wrapping during an endless stall.
    localparam int               RUN_W     = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // A producer matches a source when it writes that register, the source is
    // really read, and (optionally) the register is not the hardwired zero.
    function automatic logic src_match(
        input logic              p_valid,
        input logic              p_wr,
        input logic [REG_AW-1:0] p_rd,
        input logic [REG_AW-1:0] src,
        input logic              src_used
    );
        logic r0_masked;
        r0_masked = (R0_ZERO != 0) && (src == '0);
        return p_valid && p_wr && src_used && (p_rd == src) && !r0_masked;
    endfunction

    // Operand select for one execute source; EM holds the younger value so it
    // takes priority over MW.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (src_match(em_valid, em_RegWrite, em_rd, src, de_valid)) begin
            sel = SEL_EM;
        end else if (src_match(mw_valid, mw_RegWrite, mw_rd, src, de_valid)) begin
            sel = SEL_MW;
        end
        return sel;
    endfunction

    logic       de_hit;
    logic       em_hit;
    logic       mw_hit;
    logic       stall_all;
    logic       stall_lu;
    logic       raw_stall;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    hz_t        act;
    hz_t        hz_q;
    logic [RUN_W-1:0] run_len;

    // Decode-source hits against each producer stage
    always_comb begin
        de_hit = src_match(de_valid, de_RegWrite, de_rd, fd_rs, fd_rs_used) ||
                 src_match(de_valid, de_RegWrite, de_rd, fd_rt, fd_rt_used);
        em_hit = src_match(em_valid, em_RegWrite, em_rd, fd_rs, fd_rs_used) ||
                 src_match(em_valid, em_RegWrite, em_rd, fd_rt, fd_rt_used);
        mw_hit = src_match(mw_valid, mw_RegWrite, mw_rd, fd_rs, fd_rs_used) ||
                 src_match(mw_valid, mw_RegWrite, mw_rd, fd_rt, fd_rt_used);

        // Without forwarding the consumer waits until the producer has
        // retired; with forwarding only a load still in DE cannot be bypassed.
        stall_all = fd_valid && (de_hit || em_hit || mw_hit);
        stall_lu  = fd_valid && de_MemRead && de_hit;
        raw_stall = (FWD_EN != 0) ? stall_lu : stall_all;

        fwd_a_raw = (FWD_EN != 0) ? fwd_sel(de_rs) : SEL_RF;
        fwd_b_raw = (FWD_EN != 0) ? fwd_sel(de_rt) : SEL_RF;
    end

    // Action for this cycle: a taken branch squashes FD, which also removes
    // the stalled consumer, so flush always wins.
    always_comb begin
        act = HZ_RUN;
        if (br_taken) begin
            act = HZ_FLUSH;
        end else if (raw_stall) begin
            act = HZ_STALL;
        end
    end

    // Combinational controls are held quiet while reset is asserted
    always_comb begin
        stall      = 1'b0;
        insert_nop = 1'b0;
        flush_fd   = 1'b0;
        fwd_a      = SEL_RF;
        fwd_b      = SEL_RF;
        if (!rst) begin
            stall      = (act == HZ_STALL);
            insert_nop = (act != HZ_RUN);
            flush_fd   = (act == HZ_FLUSH);
            fwd_a      = fwd_a_raw;
            fwd_b      = fwd_b_raw;
        end
    end

    // ---- registered action state ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hz_q <= HZ_RUN;
        end else begin
            hz_q <= act;
        end
    end

    assign hz_state = hz_q;

    // ---- statistics and watchdog ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt     <= '0;
            flush_cnt     <= '0;
            run_len       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (act == HZ_STALL) begin
                if (stall_cnt != CNT_MAX) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
                if (run_len != RUN_MAX) begin
                    run_len <= run_len + RUN_W'(1);
                end
                // This stall is the MAX_STALL-th in a row
                if (run_len == RUN_LIMIT) begin
                    stall_timeout <= 1'b1;
                end
            end else begin
                run_len <= '0;
            end

            if ((act == HZ_FLUSH) && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Two hazard_ctrl instances share one set of stimulus:
//   u_fwd : FWD_EN=1, R0_ZERO=1, CNT_W=2,  MAX_STALL=4
//   u_stl : FWD_EN=0, R0_ZERO=0, CNT_W=16, MAX_STALL=8
// A behavioural model predicts every output of both instances each cycle;
// directed scenarios add fixed expectations on top.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fd_valid, fd_rs_used, fd_rt_used;
    logic [2:0] fd_rs, fd_rt;
    logic       de_valid, de_RegWrite, de_MemRead;
    logic [2:0] de_rd, de_rs, de_rt;
    logic       em_valid, em_RegWrite;
    logic [2:0] em_rd;
    logic       mw_valid, mw_RegWrite;
    logic [2:0] mw_rd;
    logic       br_taken;

    logic        st0, nop0, fl0, to0;
    logic [1:0]  fa0, fb0, hz0;
    logic [1:0]  sc0, fc0;
    logic        st1, nop1, fl1, to1;
    logic [1:0]  fa1, fb1, hz1;
    logic [15:0] sc1, fc1;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = u_fwd, 1 = u_stl
    int m_sc[2], m_fc[2], m_run[2], m_hz[2];
    bit m_to[2];
    int e_act[2], e_fa[2], e_fb[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(3), .FWD_EN(1), .R0_ZERO(1), .CNT_W(2), .MAX_STALL(4)) u_fwd (
        .clk(clk), .rst(rst),
        .fd_valid(fd_valid), .fd_rs_used(fd_rs_used), .fd_rt_used(fd_rt_used),
        .fd_rs(fd_rs), .fd_rt(fd_rt),
        .de_valid(de_valid), .de_RegWrite(de_RegWrite), .de_MemRead(de_MemRead),
        .de_rd(de_rd), .de_rs(de_rs), .de_rt(de_rt),
        .em_valid(em_valid), .em_RegWrite(em_RegWrite), .em_rd(em_rd),
        .mw_valid(mw_valid), .mw_RegWrite(mw_RegWrite), .mw_rd(mw_rd),
        .br_taken(br_taken),
        .stall(st0), .insert_nop(nop0), .flush_fd(fl0),
        .fwd_a(fa0), .fwd_b(fb0), .hz_state(hz0),
        .stall_cnt(sc0), .flush_cnt(fc0), .stall_timeout(to0)
    );

    hazard_ctrl #(.REG_AW(3), .FWD_EN(0), .R0_ZERO(0), .CNT_W(16), .MAX_STALL(8)) u_stl (
        .clk(clk), .rst(rst),
        .fd_valid(fd_valid), .fd_rs_used(fd_rs_used), .fd_rt_used(fd_rt_used),
        .fd_rs(fd_rs), .fd_rt(fd_rt),
        .de_valid(de_valid), .de_RegWrite(de_RegWrite), .de_MemRead(de_MemRead),
        .de_rd(de_rd), .de_rs(de_rs), .de_rt(de_rt),
        .em_valid(em_valid), .em_RegWrite(em_RegWrite), .em_rd(em_rd),
        .mw_valid(mw_valid), .mw_RegWrite(mw_RegWrite), .mw_rd(mw_rd),
        .br_taken(br_taken),
        .stall(st1), .insert_nop(nop1), .flush_fd(fl1),
        .fwd_a(fa1), .fwd_b(fb1), .hz_state(hz1),
        .stall_cnt(sc1), .flush_cnt(fc1), .stall_timeout(to1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit hits(input int rd, input int src, input bit used, input bit r0);
        return used && (rd == src) && !(r0 && src == 0);
    endfunction

    task automatic model_reset(input int k);
        m_sc[k] = 0; m_fc[k] = 0; m_run[k] = 0; m_hz[k] = 0; m_to[k] = 0;
    endtask

    // Action/forward prediction straight from the hazard rules
    task automatic predict(input int k);
        bit fwd, r0, haz;
        bit pw[3];
        int prd[3];
        int fa, fb;
        fwd = (k == 0);
        r0  = (k == 0);
        pw[0] = de_valid && de_RegWrite; prd[0] = de_rd;
        pw[1] = em_valid && em_RegWrite; prd[1] = em_rd;
        pw[2] = mw_valid && mw_RegWrite; prd[2] = mw_rd;
        haz = 0;
        for (int p = 0; p < 3; p++) begin
            if (fwd && (p != 0 || !de_MemRead)) continue;
            if (pw[p] && (hits(prd[p], fd_rs, fd_rs_used, r0) ||
                          hits(prd[p], fd_rt, fd_rt_used, r0))) haz = 1;
        end
        haz = haz && fd_valid;
        fa = 0; fb = 0;
        if (fwd) begin
            // walk oldest to youngest so the EM (younger) value ends up chosen
            for (int p = 2; p >= 1; p--) begin
                if (pw[p] && hits(prd[p], de_rs, de_valid, r0)) fa = (p == 1) ? 2 : 1;
                if (pw[p] && hits(prd[p], de_rt, de_valid, r0)) fb = (p == 1) ? 2 : 1;
            end
        end
        e_act[k] = rst ? 0 : (br_taken ? 2 : (haz ? 1 : 0));
        e_fa[k]  = rst ? 0 : fa;
        e_fb[k]  = rst ? 0 : fb;
    endtask

    task automatic model_update(input int k);
        int lim, cmax;
        lim  = (k == 0) ? 4 : 8;
        cmax = (k == 0) ? 3 : 65535;
        m_hz[k] = e_act[k];
        if (e_act[k] == 1) begin
            if (m_sc[k] < cmax) m_sc[k]++;
            m_run[k]++;
            if (m_run[k] >= lim) m_to[k] = 1;
        end else begin
            m_run[k] = 0;
            if (e_act[k] == 2 && m_fc[k] < cmax) m_fc[k]++;
        end
    endtask

    task automatic check_outs(input int k, input string ph);
        string p;
        p = $sformatf("%s_u%0d", ph, k);
        check({p, "_stall"}, (k == 0) ? st0 : st1, e_act[k] == 1);
        check({p, "_nop"},   (k == 0) ? nop0 : nop1, e_act[k] != 0);
        check({p, "_flush"}, (k == 0) ? fl0 : fl1, e_act[k] == 2);
        check({p, "_fwd_a"}, (k == 0) ? fa0 : fa1, e_fa[k]);
        check({p, "_fwd_b"}, (k == 0) ? fb0 : fb1, e_fb[k]);
        check({p, "_hz"},    (k == 0) ? hz0 : hz1, m_hz[k]);
        check({p, "_scnt"},  (k == 0) ? 32'(sc0) : 32'(sc1), m_sc[k]);
        check({p, "_fcnt"},  (k == 0) ? 32'(fc0) : 32'(fc1), m_fc[k]);
        check({p, "_tout"},  (k == 0) ? to0 : to1, m_to[k]);
    endtask

    // Inputs are driven just after a falling edge; combinational outputs are
    // checked 1 time unit later, registered ones just after the rising edge.
    task automatic comb_phase();
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst) model_reset(k);
            predict(k);
            check_outs(k, "c");
        end
    endtask

    task automatic edge_phase();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst) model_reset(k);
            else model_update(k);
            check_outs(k, "e");
        end
        @(negedge clk);
    endtask

    task automatic idle();
        fd_valid = 0; fd_rs_used = 0; fd_rt_used = 0; fd_rs = 0; fd_rt = 0;
        de_valid = 0; de_RegWrite = 0; de_MemRead = 0; de_rd = 0; de_rs = 0; de_rt = 0;
        em_valid = 0; em_RegWrite = 0; em_rd = 0;
        mw_valid = 0; mw_RegWrite = 0; mw_rd = 0;
        br_taken = 0;
    endtask

    task automatic reset_pulse();
        rst = 1;
        comb_phase();
        edge_phase();
        rst = 0;
    endtask

    task automatic load_use(input int r);
        idle();
        fd_valid = 1; fd_rs_used = 1; fd_rs = 3'(r);
        de_valid = 1; de_RegWrite = 1; de_MemRead = 1; de_rd = 3'(r);
    endtask

    task automatic cycle();
        comb_phase();
        edge_phase();
    endtask

    initial begin
        rst = 1;
        idle();
        @(negedge clk);
        comb_phase();
        check("rst_stall", st0, 0);
        edge_phase();
        check("rst_hz", hz0, 0);
        check("rst_scnt", sc1, 0);
        rst = 0;

        // load-use with forwarding: one stall, then the load sits in EM
        load_use(3);
        comb_phase();
        check("lu_stall", st0, 1);
        check("lu_nop", nop0, 1);
        edge_phase();
        check("lu_hz_stall", hz0, 1);
        check("lu_scnt", sc0, 1);
        de_valid = 0; de_RegWrite = 0; de_MemRead = 0;
        em_valid = 1; em_RegWrite = 1; em_rd = 3;
        comb_phase();
        check("lu_release", st0, 0);
        edge_phase();
        check("lu_hz_run", hz0, 0);
        check("lu_scnt_hold", sc0, 1);

        // forwarding priority EM over MW
        idle();
        em_valid = 1; em_RegWrite = 1; em_rd = 2;
        mw_valid = 1; mw_RegWrite = 1; mw_rd = 2;
        de_valid = 1; de_rs = 2; de_rt = 5;
        comb_phase();
        check("fwd_a_em", fa0, 2);
        check("fwd_b_rf", fb0, 0);
        check("fwd_nostall", st0, 0);
        edge_phase();
        em_valid = 0;
        comb_phase();
        check("fwd_a_mw", fa0, 1);
        edge_phase();

        // no forwarding: dependent add behind r4 writer stalls 3 cycles
        reset_pulse();
        idle();
        fd_valid = 1; fd_rs_used = 1; fd_rs = 4;
        de_valid = 1; de_RegWrite = 1; de_rd = 4;
        comb_phase(); check("s0_stall_de", st1, 1); edge_phase();
        de_valid = 0; em_valid = 1; em_RegWrite = 1; em_rd = 4;
        comb_phase(); check("s0_stall_em", st1, 1); edge_phase();
        em_valid = 0; mw_valid = 1; mw_RegWrite = 1; mw_rd = 4;
        comb_phase(); check("s0_stall_mw", st1, 1); edge_phase();
        mw_valid = 0;
        comb_phase(); check("s0_release", st1, 0); edge_phase();
        check("s0_scnt", sc1, 3);

        // branch beats load-use hazard
        reset_pulse();
        load_use(1);
        br_taken = 1;
        comb_phase();
        check("br_flush", fl0, 1);
        check("br_nop", nop0, 1);
        check("br_stall", st0, 0);
        edge_phase();
        check("br_fcnt", fc0, 1);
        check("br_scnt", sc0, 0);
        check("br_hz", hz0, 2);

        // register zero
        reset_pulse();
        load_use(0);
        em_valid = 1; em_RegWrite = 1; em_rd = 0; de_rs = 0;
        comb_phase();
        check("r0_nostall", st0, 0);
        check("r0_nofwd", fa0, 0);
        check("r0_stall_plain", st1, 1);
        edge_phase();

        // watchdog trips on the 4th consecutive stall and stays set
        reset_pulse();
        load_use(5);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check($sformatf("wd_tout_%0d", i), to0, (i >= 4));
        end
        idle();
        cycle();
        check("wd_sticky", to0, 1);
        load_use(5);
        cycle();
        rst = 1;
        comb_phase();
        check("rst_mid_stall", st0, 0);
        check("rst_mid_nop", nop0, 0);
        check("rst_mid_tout", to0, 0);
        check("rst_mid_scnt", sc0, 0);
        edge_phase();
        rst = 0;

        // counter saturation with RUN cycles between stalls
        for (int i = 0; i < 5; i++) begin
            load_use(6); cycle();
            idle(); cycle();
        end
        check("sat_scnt", sc0, 3);
        check("sat_tout", to0, 0);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) >= 3) begin
                fd_valid    = ($urandom_range(0, 3) != 0);
                fd_rs_used  = $urandom_range(0, 1);
                fd_rt_used  = $urandom_range(0, 1);
                fd_rs       = 3'($urandom_range(0, 3));
                fd_rt       = 3'($urandom_range(0, 3));
                de_valid    = ($urandom_range(0, 3) != 0);
                de_RegWrite = $urandom_range(0, 1);
                de_MemRead  = $urandom_range(0, 1);
                de_rd       = 3'($urandom_range(0, 3));
                de_rs       = 3'($urandom_range(0, 3));
                de_rt       = 3'($urandom_range(0, 3));
                em_valid    = ($urandom_range(0, 3) != 0);
                em_RegWrite = $urandom_range(0, 1);
                em_rd       = 3'($urandom_range(0, 3));
                mw_valid    = ($urandom_range(0, 3) != 0);
                mw_RegWrite = $urandom_range(0, 1);
                mw_rd       = 3'($urandom_range(0, 3));
                br_taken    = ($urandom_range(0, 9) == 0);
            end
            rst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage pipeline (FD, DE, EM, MW). It detects read-after-write hazards between the instruction in decode and older producers, and resolves them in one of two modes: stall-only (FWD_EN=0) or forward-plus-load-use-stall (FWD_EN=1). It squashes younger instructions on a taken branch resolved in execute. It also keeps saturating stall/flush statistics, a registered action state, and a sticky stall-watchdog error.

## Interface
Parameters:
- REG_AW, 3: register specifier width.
- FWD_EN, 1: 1 = forward from EM/MW and stall only on load-use; 0 = stall until the producer has left MW.
- R0_ZERO, 0: 1 = register 0 never creates a hazard or a forward.
- CNT_W, 16: statistic counter width.
- MAX_STALL, 8: consecutive-stall limit for the watchdog (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fd_valid, fd_rs_used, fd_rt_used  in  1 each  decode instruction valid; rs/rt actually read.
- fd_rs, fd_rt  in  REG_AW  decode source specifiers.
- de_valid, de_RegWrite, de_MemRead  in  1 each  execute-stage instruction attributes.
- de_rd, de_rs, de_rt  in  REG_AW  execute destination and sources.
- em_valid, em_RegWrite  in  1 each;  em_rd  in  REG_AW.
- mw_valid, mw_RegWrite  in  1 each;  mw_rd  in  REG_AW.
- br_taken  in  1  taken branch/jump resolved in execute this cycle.
- stall  out  1  hold PC and the FD register.
- insert_nop  out  1  load a bubble into DE next edge.
- flush_fd  out  1  invalidate the FD register next edge.
- fwd_a, fwd_b  out  2  execute operand select for de_rs/de_rt: 00 regfile, 10 EM, 01 MW.
- hz_state  out  2  last-cycle action: 00 RUN, 01 STALL, 10 FLUSH.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.
- stall_timeout  out  1  sticky watchdog error.

## Operation
- A producer P matches source S when all of the following hold: P_valid & P_RegWrite; P_rd == S; the source's used flag is set; and not (R0_ZERO & S == 0).
- FWD_EN=0:
  - raw_stall = fd_valid & (match on fd_rs or fd_rt against DE, EM or MW).
  - fwd_a = fwd_b = 00.
- FWD_EN=1:
  - raw_stall = fd_valid & de_MemRead & (DE matches fd_rs or fd_rt).
  - fwd_a: 10 if EM matches de_rs, else 01 if MW matches de_rs, else 00. fwd_b is the same against de_rt. EM has priority.
  - The used-flag condition for forwarding is de_valid only.
- Priority: flush wins over stall.
  - br_taken=1: flush_fd=1, insert_nop=1, stall=0.
  - Else raw_stall=1: stall=1, insert_nop=1, flush_fd=0.
  - Else all three are 0.
- stall, insert_nop, flush_fd, fwd_a and fwd_b are combinational from the current inputs and are forced to 0 while rst=1.
- hz_state register: loads FLUSH, STALL or RUN according to the action taken this cycle.
- stall_cnt increments on each STALL cycle; flush_cnt increments on each FLUSH cycle. Both hold at 2^CNT_W−1.
- Watchdog:
  - run_len (internal) increments each STALL cycle and clears on any non-STALL cycle.
  - When a STALL cycle occurs with run_len == MAX_STALL−1, stall_timeout sets.
  - stall_timeout stays set until rst; stalling behaviour is unaffected.

## Timing
- Reset values: hz_state=00, stall_cnt=0, flush_cnt=0, stall_timeout=0, run_len=0. Combinational outputs are 0 during reset.
- Reset asserted mid-stall clears everything immediately, asynchronously.
- Latency:
  - Stall, flush and forward decisions take 0 cycles, valid in the same cycle as the inputs.
  - hz_state, counters and stall_timeout reflect a cycle's action after that cycle's rising edge.
- Load-use (FWD_EN=1): exactly 1 stall cycle, after which the load sits in EM.
- FWD_EN=0 dependence on a DE producer: 3 stall cycles. On an EM producer: 2. On an MW producer: 1.
- Simultaneous br_taken and hazard: only FLUSH is counted; run_len clears.
- Invalid (bubble) stages never match.

## Test plan
- FWD_EN=1, de={valid,RegWrite,MemRead, rd=3}, fd={valid, rs=3 used} -> stall=insert_nop=1 for 1 cycle; stall_cnt 0→1; hz_state=01 then 00.
- FWD_EN=1, em rd=2 and mw rd=2 both writing, de_rs=2, de_rt=5 -> fwd_a=10, fwd_b=00, no stall. Remove em -> fwd_a=01.
- FWD_EN=0, dependent add directly behind an add writing r4 -> exactly 3 stall cycles, then release; stall_cnt=3.
- br_taken=1 while a load-use hazard is present -> flush_fd=1, insert_nop=1, stall=0; flush_cnt=1, stall_cnt unchanged, hz_state=10.
- R0_ZERO=1, producer rd=0 and fd_rs=0 -> no stall, no forward. With R0_ZERO=0 -> stall.
- MAX_STALL=4, hold a hazard 5 cycles -> stall_timeout rises after the 4th stall edge and stays 1 after the hazard clears. Assert rst mid-stall -> all outputs 0 at once.
- CNT_W=2, 5 stall cycles separated by RUN cycles -> stall_cnt saturates at 3.
